// File: rtl/dcache_nway.sv
// N-way set-associative write-back data cache with round-robin replacement.
// Optional hit/miss counters are compiled in when DCACHE_PERF_CNT_EN is defined.
module dcache_nway #(
  parameter int WAYS      = 2,
  parameter int INDEX_WD  = 7,
  parameter int OFFSET_WD = 5
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      data_sram_en,
  input  logic [3:0]                data_sram_wen,
  input  logic [31:0]               data_sram_addr,
  input  logic [31:0]               data_sram_wdata,
  output logic [31:0]               data_sram_rdata,
  output logic                      stallreq,
  output logic                      rd_req,
  output logic [31:0]               rd_addr,
  input  logic                      rd_valid,
  input  logic [(8<<OFFSET_WD)-1:0] rd_line,
  output logic                      wr_req,
  output logic [31:0]               wr_addr,
  output logic [(8<<OFFSET_WD)-1:0] wr_line,
`ifdef DCACHE_PERF_CNT_EN
  input  logic                      wr_done,
  output logic [31:0]               hit_cnt,
  output logic [31:0]               miss_cnt
`else
  input  logic                      wr_done
`endif
);
  localparam int SETS      = 1 << INDEX_WD;
  localparam int LINE_BITS = 8 << OFFSET_WD;
  localparam int TAG_WD    = 32 - INDEX_WD - OFFSET_WD;
  localparam int WAY_WD    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;
  state_t r_state, w_state_nxt;

  logic [WAYS-1:0]      r_valid [SETS];
  logic [WAYS-1:0]      r_dirty [SETS];
  logic [WAY_WD-1:0]    r_rr    [SETS];
  logic [TAG_WD-1:0]    r_tag   [WAYS][SETS];
  logic [LINE_BITS-1:0] r_data  [WAYS][SETS];

  logic [31-OFFSET_WD:0] r_line_addr;
  logic [WAY_WD-1:0]     r_victim;
  logic [31:0]           r_rdata;

  logic [INDEX_WD-1:0]   w_set, w_rset;
  logic [TAG_WD-1:0]     w_tag;
  logic [OFFSET_WD+2:0]  w_word_lsb;
  logic [WAYS-1:0]       w_match;
  logic [WAY_WD-1:0]     w_hit_way, w_victim;
  logic                  w_hit, w_miss, w_victim_dirty, w_fill;
  logic [31:0]           w_hit_word;
  logic                  w_unused;

  assign w_set      = data_sram_addr[INDEX_WD+OFFSET_WD-1:OFFSET_WD];
  assign w_tag      = data_sram_addr[31:INDEX_WD+OFFSET_WD];
  assign w_word_lsb = {data_sram_addr[OFFSET_WD-1:2], 5'b0};
  assign w_rset     = r_line_addr[INDEX_WD-1:0];
  assign w_unused   = ^data_sram_addr[1:0];

  always_comb begin
    w_match   = '0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_set][w] && (r_tag[w][w_set] == w_tag)) begin
        w_match[w] = 1'b1;
        w_hit_way  = WAY_WD'(w);
      end
    end
  end

  // Lowest-numbered invalid way wins; otherwise the set's round-robin pointer.
  always_comb begin
    w_victim = r_rr[w_set];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_set][w]) w_victim = WAY_WD'(w);
    end
  end

  assign w_hit          = resetn && (r_state == IDLE) && data_sram_en && $onehot(w_match);
  assign w_miss         = resetn && (r_state == IDLE) && data_sram_en && !$onehot(w_match);
  assign w_victim_dirty = r_valid[w_set][w_victim] && r_dirty[w_set][w_victim];
  assign w_hit_word     = r_data[w_hit_way][w_set][w_word_lsb +: 32];
  assign w_fill         = resetn && (r_state == REFILL) && rd_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_miss) w_state_nxt = w_victim_dirty ? WB : REFILL;
      WB:      if (wr_done) w_state_nxt = REFILL;
      REFILL:  if (rd_valid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshakes: wr_req/wr_addr/wr_line hold until wr_done is sampled high at a
  // clock edge; rd_req/rd_addr hold until rd_valid is sampled high, and rd_line
  // is captured on that same edge. All requests read as 0 while resetn is low.
  assign stallreq        = resetn && (w_miss || (r_state != IDLE));
  assign rd_req          = resetn && (r_state == REFILL);
  assign wr_req          = resetn && (r_state == WB);
  assign rd_addr         = {r_line_addr, {OFFSET_WD{1'b0}}};
  assign wr_addr         = {r_tag[r_victim][w_rset], w_rset, {OFFSET_WD{1'b0}}};
  assign wr_line         = r_data[r_victim][w_rset];
  assign data_sram_rdata = resetn ? r_rdata : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_rdata <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_rdata <= (w_hit && (data_sram_wen == 4'b0)) ? w_hit_word : '0;
      if (w_hit && (|data_sram_wen)) r_dirty[w_set][w_hit_way] <= 1'b1;
      if (w_fill) begin
        r_valid[w_rset][r_victim] <= 1'b1;
        r_dirty[w_rset][r_victim] <= 1'b0;
        r_rr[w_rset] <= (r_rr[w_rset] == WAY_WD'(WAYS - 1)) ? '0 : r_rr[w_rset] + 1'b1;
      end
    end
  end

  // Storage arrays carry no reset so they map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_miss) begin
      r_line_addr <= data_sram_addr[31:OFFSET_WD];
      r_victim    <= w_victim;
    end
    if (w_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wen[b])
          r_data[w_hit_way][w_set][w_word_lsb + 8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
    if (w_fill) begin
      r_data[r_victim][w_rset] <= rd_line;
      r_tag[r_victim][w_rset]  <= r_line_addr[31-OFFSET_WD:INDEX_WD];
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit)  r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_nway.sv
// Randomized bench for dcache_nway against a transaction-level cache/memory model;
// counter ports are checked when DCACHE_PERF_CNT_EN is defined.
module tb_dcache_nway;
  localparam int WAYS      = 2;
  localparam int INDEX_WD  = 7;
  localparam int OFFSET_WD = 5;
  localparam int SETS      = 1 << INDEX_WD;
  localparam int LINE_BITS = 8 << OFFSET_WD;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 data_sram_en = 1'b0;
  logic [3:0]           data_sram_wen = '0;
  logic [31:0]          data_sram_addr = '0;
  logic [31:0]          data_sram_wdata = '0;
  logic [31:0]          data_sram_rdata;
  logic                 stallreq, rd_req, wr_req;
  logic [31:0]          rd_addr, wr_addr;
  logic                 rd_valid = 1'b0;
  logic [LINE_BITS-1:0] rd_line = '0;
  logic [LINE_BITS-1:0] wr_line;
  logic                 wr_done = 1'b0;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]          hit_cnt, miss_cnt;
`endif

  dcache_nway #(.WAYS(WAYS), .INDEX_WD(INDEX_WD), .OFFSET_WD(OFFSET_WD)) dut (
    .clk(clk), .resetn(resetn),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .stallreq(stallreq),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_line(rd_line),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_line(wr_line),
`ifdef DCACHE_PERF_CNT_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .wr_done(wr_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  bit                   m_valid [SETS][WAYS];
  bit                   m_dirty [SETS][WAYS];
  logic [31:0]          m_la    [SETS][WAYS];
  logic [LINE_BITS-1:0] m_line  [SETS][WAYS];
  int                   m_ptr   [SETS];
  logic [LINE_BITS-1:0] mem [logic [31:0]];
  int unsigned          m_hits = 0, m_misses = 0;

  // ---------------- scoreboard ----------------
  int                   n_vec = 0, n_err = 0;
  bit                   chk = 0, chk_cnt = 0;
  logic                 e_stall, e_rd_req, e_wr_req;
  logic [31:0]          e_rd_addr, e_wr_addr, e_rdata;
  logic [LINE_BITS-1:0] e_wr_line;
  logic [31:0]          e_hit_cnt, e_miss_cnt;
  logic [31:0]          exp_q[$];

  // Per-access observations of the model, pinned against literals.
  bit                   o_first_stall, o_saw_wr;
  int                   o_wr_cycles;
  logic [31:0]          o_wr_addr, o_rd_addr, o_rdata;

  task automatic check(input string nm, input logic [LINE_BITS-1:0] act,
                       input logic [LINE_BITS-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("stallreq", stallreq, e_stall);
      check("rd_req", rd_req, e_rd_req);
      check("wr_req", wr_req, e_wr_req);
      check("rdata", data_sram_rdata, e_rdata);
      if (e_rd_req) check("rd_addr", rd_addr, e_rd_addr);
      if (e_wr_req) begin
        check("wr_addr", wr_addr, e_wr_addr);
        check("wr_line", wr_line, e_wr_line);
      end
`ifdef DCACHE_PERF_CNT_EN
      if (chk_cnt) begin
        check("hit_cnt", hit_cnt, e_hit_cnt);
        check("miss_cnt", miss_cnt, e_miss_cnt);
      end
`endif
    end
  end

  // ---------------- model helpers ----------------
  function automatic logic [LINE_BITS-1:0] get_line(input logic [31:0] la);
    logic [LINE_BITS-1:0] l;
    if (!mem.exists(la)) begin
      for (int i = 0; i < LINE_BITS / 32; i++) l[i*32 +: 32] = $urandom;
      mem[la] = l;
    end
    return mem[la];
  endfunction

  function automatic int lookup(input logic [31:0] a);
    int s;
    s = int'(a[INDEX_WD+OFFSET_WD-1:OFFSET_WD]);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_la[s][w] == {a[31:OFFSET_WD], 5'b0}) return w;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle_start();
    @(posedge clk); #1;
    resetn    = 1'b1;
    e_rdata   = exp_q.pop_front();
    exp_q.push_back('0);
    e_hit_cnt = m_hits;
    e_miss_cnt = m_misses;
    e_stall = 0; e_rd_req = 0; e_wr_req = 0;
    rd_valid = 0; wr_done = 0;
    for (int i = 0; i < LINE_BITS / 32; i++) rd_line[i*32 +: 32] = $urandom;
  endtask

  task automatic hit_apply(input logic [31:0] a, input logic [3:0] we,
                           input logic [31:0] wd, input int w);
    int s, wo;
    s  = int'(a[INDEX_WD+OFFSET_WD-1:OFFSET_WD]);
    wo = int'(a[OFFSET_WD-1:2]);
    m_hits++;
    if (we == 4'b0) begin
      o_rdata = m_line[s][w][wo*32 +: 32];
      void'(exp_q.pop_back());
      exp_q.push_back(o_rdata);
    end else begin
      for (int b = 0; b < 4; b++)
        if (we[b]) m_line[s][w][wo*32 + b*8 +: 8] = wd[b*8 +: 8];
      m_dirty[s][w] = 1;
    end
  endtask

  task automatic idle();
    cycle_start();
    data_sram_en = 0; data_sram_addr = $urandom; data_sram_wen = 4'($urandom);
    rd_valid = 1'($urandom); wr_done = 1'($urandom);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      cycle_start();
      resetn = 0;
      e_rdata = '0;
      data_sram_en = 1'($urandom); rd_valid = 1'($urandom); wr_done = 1'($urandom);
      for (int s = 0; s < SETS; s++) begin
        m_ptr[s] = 0;
        for (int w = 0; w < WAYS; w++) begin m_valid[s][w] = 0; m_dirty[s][w] = 0; end
      end
      m_hits = 0; m_misses = 0;
    end
  endtask

  task automatic access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                        input int wb_len, input int rf_len, input bit drop);
    int s, w, v;
    logic [31:0] la;
    s  = int'(a[INDEX_WD+OFFSET_WD-1:OFFSET_WD]);
    la = {a[31:OFFSET_WD], 5'b0};
    o_saw_wr = 0; o_wr_cycles = 0; o_wr_addr = '0; o_rd_addr = '0; o_rdata = '0;
    cycle_start();
    data_sram_en = 1; data_sram_addr = a; data_sram_wen = we; data_sram_wdata = wd;
    rd_valid = 1'($urandom); wr_done = 1'($urandom);
    w = lookup(a);
    o_first_stall = (w < 0);
    if (w >= 0) begin
      hit_apply(a, we, wd, w);
      return;
    end
    e_stall = 1;
    m_misses++;
    v = -1;
    for (int i = 0; i < WAYS; i++) if (v < 0 && !m_valid[s][i]) v = i;
    if (v < 0) v = m_ptr[s];
    if (m_valid[s][v] && m_dirty[s][v]) begin
      o_saw_wr = 1; o_wr_addr = m_la[s][v];
      for (int i = 0; i < wb_len; i++) begin
        cycle_start();
        if (drop) begin data_sram_en = 1'($urandom); data_sram_addr = $urandom; end
        e_stall = 1; e_wr_req = 1; e_wr_addr = m_la[s][v]; e_wr_line = m_line[s][v];
        rd_valid = 1'($urandom); wr_done = (i == wb_len - 1);
        o_wr_cycles++;
      end
      mem[m_la[s][v]] = m_line[s][v];
    end
    for (int i = 0; i < rf_len; i++) begin
      cycle_start();
      if (drop) begin data_sram_en = 1'($urandom); data_sram_addr = $urandom; end
      e_stall = 1; e_rd_req = 1; e_rd_addr = la;
      wr_done = 1'($urandom);
      if (i == rf_len - 1) begin rd_valid = 1; rd_line = get_line(la); end
    end
    o_rd_addr = la;
    m_valid[s][v] = 1; m_dirty[s][v] = 0; m_la[s][v] = la; m_line[s][v] = get_line(la);
    m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    cycle_start();
    if (drop) begin
      data_sram_en = 0;
    end else begin
      data_sram_en = 1; data_sram_addr = a; data_sram_wen = we; data_sram_wdata = wd;
      hit_apply(a, we, wd, v);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [LINE_BITS-1:0] pre;
    logic [31:0] a;
    int tg, st;
    exp_q.push_back('0);
    chk = 1;
    do_reset(3);
    chk_cnt = 1;

    for (int i = 0; i < LINE_BITS / 32; i++) pre[i*32 +: 32] = $urandom;
    pre[31:0]  = 32'hDEAD_BEEF;
    pre[63:32] = 32'h1111_1111;
    mem[32'h0000_1000] = pre;

    access(32'h0000_1000, 4'b0000, 32'h0, 1, 2, 0);
    check("pin_cold_stall", o_first_stall, 1'b1);
    check("pin_cold_no_wr", o_saw_wr, 1'b0);
    check("pin_cold_rd_addr", o_rd_addr, 32'h0000_1000);
    check("pin_cold_rdata", o_rdata, 32'hDEAD_BEEF);

    access(32'h0000_1004, 4'b0011, 32'h0000_5A5A, 1, 1, 0);
    check("pin_store_no_stall", o_first_stall, 1'b0);
    access(32'h0000_1004, 4'b0000, 32'h0, 1, 1, 0);
    check("pin_store_merge", o_rdata, 32'h1111_5A5A);

    access(32'h0000_2000, 4'b0000, 32'h0, 1, 3, 0);
    access(32'h0000_1000, 4'b0000, 32'h0, 1, 1, 0);
    check("pin_reread", o_rdata, 32'hDEAD_BEEF);
`ifdef DCACHE_PERF_CNT_EN
    check("pin_hit_count", m_hits, 32'd5);
    check("pin_miss_count", m_misses, 32'd2);
`endif

    access(32'h0000_3000, 4'b0000, 32'h0, 3, 2, 0);
    check("pin_evict_wr", o_saw_wr, 1'b1);
    check("pin_evict_wr_addr", o_wr_addr, 32'h0000_1000);
    check("pin_evict_wr_cycles", o_wr_cycles, 32'd3);
    check("pin_evict_rd_addr", o_rd_addr, 32'h0000_3000);
    idle();

    // Reset in the middle of a refill of 0x4000 (victim 0x2000 is clean).
    cycle_start();
    data_sram_en = 1; data_sram_addr = 32'h0000_4000; data_sram_wen = 4'b0;
    check("pin_abort_miss", lookup(32'h0000_4000), -1);
    check("pin_abort_victim_clean", m_dirty[0][m_ptr[0]], 1'b0);
    e_stall = 1; m_misses++;
    cycle_start();
    e_stall = 1; e_rd_req = 1; e_rd_addr = 32'h0000_4000;
    do_reset(1);
    idle();
    access(32'h0000_4000, 4'b0000, 32'h0, 1, 2, 0);
    check("pin_post_reset_miss", o_first_stall, 1'b1);

    for (int n = 0; n < 400; n++) begin
      tg = $urandom_range(1, 5);
      st = $urandom_range(0, 2);
      a  = (32'(tg) << 12) | (32'(st * 3) << 5) | (32'($urandom_range(0, 7)) << 2);
      access(a, ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)), $urandom,
             $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) idle();
      if ($urandom_range(0, 99) == 0) do_reset(1);
    end
    idle();
    idle();
    @(posedge clk);
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache_nway.md
DCACHE_NWAY -- requirements
Module: dcache_nway

Interface
REQ-001 SHALL have parameter WAYS, default 2: associativity; power of two, 1..8.
REQ-002 SHALL have parameter INDEX_WD, default 7: set index width; SETS = 2^INDEX_WD.
REQ-003 SHALL have parameter OFFSET_WD, default 5: line offset width; LINE_BITS = 8<<OFFSET_WD; TAG_WD = 32-INDEX_WD-OFFSET_WD.
REQ-004 SHALL use reset resetn, synchronous, active-low, and clock clk.
REQ-005 Ports, in order:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- data_sram_en  in  1  CPU access request
- data_sram_wen  in  4  byte write enables; 0 = read
- data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  store data
- data_sram_rdata  out  32  load data
- stallreq  out  1  pipeline stall
- rd_req  out  1  refill request
- rd_addr  out  32  line-aligned refill address
- rd_valid  in  1  refill line present
- rd_line  in  LINE_BITS  refill data
- wr_req  out  1  write-back request
- wr_addr  out  32  line-aligned victim address
- wr_line  out  LINE_BITS  victim data
- wr_done  in  1  write-back accepted

Function
REQ-006 Lookup SHALL compare {valid, tag} of all WAYS ways of set addr[INDEX_WD+OFFSET_WD-1:OFFSET_WD] combinationally in IDLE; hit = data_sram_en and exactly one way matching.
REQ-007 Read hit SHALL keep stallreq 0; data_sram_rdata SHALL present the addressed word on the following cycle; otherwise data_sram_rdata SHALL be 0.
REQ-008 Write hit SHALL update the enabled bytes at the clock edge and set that way's dirty bit.
REQ-009 FSM states SHALL be IDLE, WB and REFILL.
REQ-010 IDLE miss SHALL latch the address, select the victim, and go to WB if the victim is valid and dirty, else to REFILL.
REQ-011 Victim SHALL be the lowest-numbered invalid way, else the way given by the per-set round-robin pointer.
REQ-012 In WB, wr_req SHALL be 1, and wr_addr/wr_line SHALL hold the victim address and data stable until wr_done is sampled 1; the FSM then SHALL go to REFILL.
REQ-013 In REFILL, rd_req SHALL be 1 with rd_addr = {latched addr[31:OFFSET_WD], 0} until rd_valid is sampled 1.
REQ-014 On that same edge the cache SHALL write rd_line, tag, valid=1 and dirty=0 into the victim, advance the set's pointer modulo WAYS, and return to IDLE.
REQ-015 After refill, IDLE SHALL replay the request as a hit (write-allocate for stores).
REQ-016 stallreq SHALL equal (IDLE and data_sram_en and not hit) or (state != IDLE).
REQ-017 Upstream SHALL hold its request stable while stallreq=1; a request dropped mid-miss SHALL still complete the refill.
REQ-018 rd_valid in IDLE/WB and wr_done in IDLE/REFILL SHALL be ignored.
REQ-019 rd_req and wr_req SHALL never both be 1.

Reset
REQ-020 resetn=0 SHALL force IDLE and clear all valid bits, dirty bits and round-robin pointers; tag/data arrays SHALL not be reset.
REQ-021 During and after reset, stallreq, rd_req, wr_req and data_sram_rdata SHALL be 0; reset mid-miss SHALL abandon the transfer and take effect on the next edge.

Configuration
REQ-022 With macro DCACHE_PERF_CNT_EN defined, the module SHALL add outputs hit_cnt (32) and miss_cnt (32), reset to 0, incremented once per IDLE hit cycle and once per miss entry respectively, wrapping at 2^32.
REQ-023 Without DCACHE_PERF_CNT_EN, these ports and counters SHALL be absent, with all other behaviour identical.

Verification
REQ-024 Read 0x0000_1000 after reset -> stallreq=1, rd_req=1, rd_addr=0x0000_1000, no wr_req; rd_valid with word0=0xDEADBEEF -> next replay cycle stallreq=0, following cycle rdata=0xDEADBEEF.
REQ-025 Store wen=4'b0011, wdata=0x0000_5A5A to a cached line holding 0x1111_1111 -> no stall; reread returns 0x1111_5A5A; dirty=1.
REQ-026 WAYS=2: fill 0x1000, 0x2000 (same set), dirty 0x1000, then read 0x3000 -> wr_req with wr_addr=0x1000 held 3 cycles until wr_done, then rd_req with rd_addr=0x3000.
REQ-027 Assert resetn=0 during REFILL -> rd_req=0 next cycle; rereading the line misses again.
REQ-028 With DCACHE_PERF_CNT_EN: 3 hits and 2 misses -> hit_cnt=5 (2 replay hits included), miss_cnt=2.
